// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
//
// Data-side bridge between the MiniMIPS32 data port and up to 16 synchronous
// memory-mapped slaves. A 4-bit region field of the CPU byte address selects
// one slave channel. Writes are posted in a single cycle. Reads are answered
// RD_LAT cycles after acceptance. When RD_LAT > 1 the CPU is held with
// 'stall' until the last wait cycle.
//
// Optional feature (macro DMEM_BUS_ERR_EN): adds bus_err / err_addr reporting
// of accesses to unmapped regions. When the macro is undefined, those ports
// are absent. Unmapped writes are then dropped and unmapped reads return 0.
//
// Parameters
//   NUM_SLV  number of slave channels (1..16)
//   RD_LAT   slave read latency in cycles (1..4)
//   SEL_LSB  LSB of region field daddr[SEL_LSB+3:SEL_LSB]
//   AW_SLV   slave word-address width, s_addr = daddr[AW_SLV+1:2]
//
// Ports
//   cpu_clk_50M  in   clock, rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   dce          in   CPU data access enable
//   daddr        in   CPU byte address
//   we           in   CPU byte write enables (0 = read)
//   din          in   CPU write data
//   dm           out  read data to CPU (0 outside the response cycle)
//   stall        out  CPU hold request (combinational)
//   s_ce         out  per-slave enable, one-hot or zero
//   s_we         out  per-slave byte enables, slave i at [4i+3:4i]
//   s_addr       out  shared slave word address
//   s_din        out  shared slave write data
//   s_dout       in   slave read data, slave i at [32i+31:32i]
//   bus_err      out  (DMEM_BUS_ERR_EN) one-cycle unmapped-access pulse
//   err_addr     out  (DMEM_BUS_ERR_EN) address of the last unmapped access
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
  parameter int NUM_SLV = 2,
  parameter int RD_LAT  = 1,
  parameter int SEL_LSB = 28,
  parameter int AW_SLV  = 11
) (
  input  logic                    cpu_clk_50M,
  input  logic                    cpu_rst_n,
  input  logic                    dce,
  input  logic [31:0]             daddr,
  input  logic [3:0]              we,
  input  logic [31:0]             din,
  output logic [31:0]             dm,
  output logic                    stall,
  output logic [NUM_SLV-1:0]      s_ce,
  output logic [4*NUM_SLV-1:0]    s_we,
  output logic [AW_SLV-1:0]       s_addr,
  output logic [31:0]             s_din,
  input  logic [32*NUM_SLV-1:0]   s_dout
`ifdef DMEM_BUS_ERR_EN
  ,
  output logic                    bus_err,
  output logic [31:0]             err_addr
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  // Last wait-cycle count. Only meaningful when RD_LAT > 1.
  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic [3:0] idx_q;
  logic       rmap_q;     // the read in flight targeted a mapped region
  logic       rpend_q;    // a multi-cycle read is waiting for its data
  logic       rvalid_q;   // this cycle is the response cycle of a read
  logic       resp_next;

  logic [3:0] idx;
  logic       mapped;
  logic       accept;
  logic       rd_acc;
  logic       unused_bits;

  assign idx    = daddr[SEL_LSB+3:SEL_LSB];
  assign mapped = (32'(idx) < NUM_SLV);

  // Reset gates acceptance so that a read held on the bus during reset
  // neither enables a slave nor raises stall.
  assign accept = cpu_rst_n && dce && (state_reg == IDLE);
  assign rd_acc = accept && (we == 4'b0);

  assign s_addr = daddr[AW_SLV+1:2];
  assign s_din  = din;

  // Only the region field and word address are decoded. The rest of daddr
  // is deliberately ignored.
  assign unused_bits = ^daddr;

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_chan
    assign s_ce[gi]         = accept && mapped && (idx == 4'(gi));
    assign s_we[4*gi +: 4]  = s_ce[gi] ? we : 4'b0;
  end

  // Response mux. idx_q is captured at acceptance, so a new request issued
  // in the response cycle cannot disturb the data being returned.
  always_comb begin
    dm = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (rvalid_q && rmap_q && (idx_q == 4'(i))) begin
        dm = s_dout[32*i +: 32];
      end
    end
  end

  // Next-state / stall logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    resp_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rd_acc) begin
          if (RD_LAT == 1) begin
            resp_next = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = WAIT;
            cnt_next   = 2'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == CNT_LAST) begin
          // Release the CPU one cycle before the data shows up on dm.
          state_next = IDLE;
          cnt_next   = 2'd0;
          resp_next  = rpend_q;
        end else begin
          stall    = 1'b1;
          cnt_next = cnt_reg + 2'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      idx_q     <= 4'd0;
      rmap_q    <= 1'b0;
      rpend_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rvalid_q  <= resp_next;
      if (rd_acc) begin
        idx_q   <= idx;
        rmap_q  <= mapped;
        rpend_q <= (RD_LAT > 1);
      end else if (resp_next) begin
        rpend_q <= 1'b0;
      end
    end
  end

`ifdef DMEM_BUS_ERR_EN
  logic werr_q;

  // Write errors surface the cycle after acceptance. Read errors surface
  // with the (zero) read data in the response cycle.
  assign bus_err = werr_q || (rvalid_q && !rmap_q);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      werr_q   <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      werr_q <= accept && !mapped && (we != 4'b0);
      if (accept && !mapped) begin
        err_addr <= daddr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
//
// Three bridges (RD_LAT = 1, 3, 4; NUM_SLV = 2) each drive a pair of
// behavioural slaves with a matching read pipeline. The reference model
// keeps a shadow copy of every slave word and a per-cycle schedule of the
// data and error pulses that must appear. Directed accesses come first, then
// randomized reads/writes with random idle gaps (including back-to-back).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_bus_bridge;

  localparam int ND = 3;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst_n_v  [ND];
  logic              dce_v    [ND];
  logic [31:0]       daddr_v  [ND];
  logic [3:0]        we_v     [ND];
  logic [31:0]       din_v    [ND];
  logic [31:0]       dm_v     [ND];
  logic              stall_v  [ND];
  logic [NS-1:0]     s_ce_v   [ND];
  logic [4*NS-1:0]   s_we_v   [ND];
  logic [10:0]       s_addr_v [ND];
  logic [31:0]       s_din_v  [ND];
`ifdef DMEM_BUS_ERR_EN
  logic              bus_err_v  [ND];
  logic [31:0]       err_addr_v [ND];
`endif

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

    logic [32*NS-1:0] s_dout;
    logic [31:0]      mem [NS][16];
    logic             pv  [4];
    logic             ps  [4];
    logic [31:0]      pd  [4];

    dmem_bus_bridge #(
      .NUM_SLV (NS),
      .RD_LAT  (L),
      .SEL_LSB (28),
      .AW_SLV  (11)
    ) u_dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n_v[gi]),
      .dce         (dce_v[gi]),
      .daddr       (daddr_v[gi]),
      .we          (we_v[gi]),
      .din         (din_v[gi]),
      .dm          (dm_v[gi]),
      .stall       (stall_v[gi]),
      .s_ce        (s_ce_v[gi]),
      .s_we        (s_we_v[gi]),
      .s_addr      (s_addr_v[gi]),
      .s_din       (s_din_v[gi]),
      .s_dout      (s_dout)
`ifdef DMEM_BUS_ERR_EN
      ,
      .bus_err     (bus_err_v[gi]),
      .err_addr    (err_addr_v[gi])
`endif
    );

    // Slaves: byte-writable words, read data delivered L cycles after the
    // enable cycle. Outside a delivery cycle the bus carries junk so that
    // any leak through dm is visible.
    always @(posedge clk) begin
      pv[0] <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (s_ce_v[gi][i]) begin
          if (s_we_v[gi][4*i +: 4] == 4'b0) begin
            pv[0] <= 1'b1;
            ps[0] <= 1'(i);
            pd[0] <= mem[i][s_addr_v[gi][3:0]];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (s_we_v[gi][4*i+b]) mem[i][s_addr_v[gi][3:0]][8*b +: 8] <= s_din_v[gi][8*b +: 8];
            end
          end
        end
      end
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        ps[k] <= ps[k-1];
        pd[k] <= pd[k-1];
      end
    end

    always_comb begin
      s_dout = '0;
      for (int i = 0; i < NS; i++) begin
        s_dout[32*i +: 32] = (pv[L-1] && (ps[L-1] == 1'(i))) ? pd[L-1] : (32'hBAD0_0000 + 32'(i));
      end
    end
  end

  // Reference model state.
  logic [31:0] shadow [ND][NS][16];
  logic [31:0] exp_dm    [int];
  bit          exp_err   [int];
  logic [31:0] exp_eaddr [int];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int key(input int d, input int c);
    return d * 1000000 + c;
  endfunction

  // Per-cycle response checks, called shortly after a falling edge.
  task automatic check_cycle(input int d);
    int k;
    k = key(d, cyc);
    check_val($sformatf("d%0d dm", d), dm_v[d], exp_dm.exists(k) ? exp_dm[k] : 32'h0);
`ifdef DMEM_BUS_ERR_EN
    check_val($sformatf("d%0d bus_err", d), 32'(bus_err_v[d]), exp_err.exists(k) ? 32'h1 : 32'h0);
    if (exp_err.exists(k)) check_val($sformatf("d%0d err_addr", d), err_addr_v[d], exp_eaddr[k]);
`endif
  endtask

  task automatic idle(input int d);
    dce_v[d]   = 1'b0;
    we_v[d]    = 4'($urandom);
    daddr_v[d] = $urandom;
    #1;
    check_val($sformatf("d%0d idle s_ce", d), 32'(s_ce_v[d]), 32'h0);
    check_val($sformatf("d%0d idle s_we", d), 32'(s_we_v[d]), 32'h0);
    check_val($sformatf("d%0d idle stall", d), 32'(stall_v[d]), 32'h0);
    check_cycle(d);
    @(negedge clk);
  endtask

  // One CPU access, started at a falling edge; returns at the falling edge
  // of the first cycle in which the CPU may issue its next access.
  task automatic txn(input int d, input logic [31:0] a, input logic [3:0] w, input logic [31:0] dat);
    int L;
    int idx;
    int wa;
    int c0;
    bit mapped;
    logic [NS-1:0]   ece;
    logic [4*NS-1:0] ewe;
    L      = lat_of(d);
    idx    = int'(a[31:28]);
    wa     = int'(a[5:2]);
    mapped = (idx < NS);
    dce_v[d] = 1'b1; daddr_v[d] = a; we_v[d] = w; din_v[d] = dat;
    #1;
    c0  = cyc;
    ece = '0;
    ewe = '0;
    if (mapped) begin
      ece[idx]         = 1'b1;
      ewe[4*idx +: 4]  = w;
    end
    check_val($sformatf("d%0d s_ce", d),   32'(s_ce_v[d]),   32'(ece));
    check_val($sformatf("d%0d s_we", d),   32'(s_we_v[d]),   32'(ewe));
    check_val($sformatf("d%0d s_addr", d), 32'(s_addr_v[d]), 32'(a[12:2]));
    check_val($sformatf("d%0d s_din", d),  s_din_v[d],       dat);
    check_val($sformatf("d%0d stall0", d), 32'(stall_v[d]),  ((w == 4'b0) && (L > 1)) ? 32'h1 : 32'h0);
    check_cycle(d);
    if (w != 4'b0) begin
      if (mapped) begin
        for (int b = 0; b < 4; b++) if (w[b]) shadow[d][idx][wa][8*b +: 8] = dat[8*b +: 8];
      end else begin
        exp_err[key(d, c0 + 1)]   = 1'b1;
        exp_eaddr[key(d, c0 + 1)] = a;
      end
    end else begin
      exp_dm[key(d, c0 + L)] = mapped ? shadow[d][idx][wa] : 32'h0;
      if (!mapped) begin
        exp_err[key(d, c0 + L)]   = 1'b1;
        exp_eaddr[key(d, c0 + L)] = a;
      end
    end
    $display("txn d%0d cyc %0d %s addr %08h we %h din %08h", d, c0,
             (w == 4'b0) ? "RD" : "WR", a, w, dat);
    for (int k = 1; k < L && w == 4'b0; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("d%0d wait s_ce", d), 32'(s_ce_v[d]), 32'h0);
      check_val($sformatf("d%0d wait s_we", d), 32'(s_we_v[d]), 32'h0);
      check_val($sformatf("d%0d wait stall", d), 32'(stall_v[d]), (k < L - 1) ? 32'h1 : 32'h0);
      check_cycle(d);
    end
    @(negedge clk);
  endtask

  // Read accepted, then reset in the first wait cycle: the read must vanish.
  task automatic reset_mid_wait(input int d);
    int c0;
    dce_v[d] = 1'b1; daddr_v[d] = 32'h1000_0000; we_v[d] = 4'h0;
    #1;
    c0 = cyc;
    check_val($sformatf("d%0d rst s_ce0", d), 32'(s_ce_v[d]), 32'h2);
    check_val($sformatf("d%0d rst stall0", d), 32'(stall_v[d]), 32'h1);
    check_cycle(d);
    @(negedge clk);
    rst_n_v[d] = 1'b0;
    #1;
    check_val($sformatf("d%0d rst stall1", d), 32'(stall_v[d]), 32'h0);
    check_val($sformatf("d%0d rst s_ce1", d), 32'(s_ce_v[d]), 32'h0);
    check_cycle(d);
    @(negedge clk);
    #1;
    check_val($sformatf("d%0d rst stall2", d), 32'(stall_v[d]), 32'h0);
    check_cycle(d);
    rst_n_v[d] = 1'b1;
    dce_v[d]   = 1'b0;
    $display("txn d%0d cyc %0d RD addr 10000000 interrupted by reset", d, c0);
    @(negedge clk);
    repeat (4) idle(d);
  endtask

  initial begin
    int idle_gaps;
    for (int d = 0; d < ND; d++) begin
      rst_n_v[d] = 1'b0; dce_v[d] = 1'b1; daddr_v[d] = 32'h0; we_v[d] = 4'h0; din_v[d] = 32'h0;
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("d%0d reset dm", d),    dm_v[d],            32'h0);
      check_val($sformatf("d%0d reset stall", d), 32'(stall_v[d]),    32'h0);
      check_val($sformatf("d%0d reset s_ce", d),  32'(s_ce_v[d]),     32'h0);
      check_val($sformatf("d%0d reset s_we", d),  32'(s_we_v[d]),     32'h0);
`ifdef DMEM_BUS_ERR_EN
      check_val($sformatf("d%0d reset bus_err", d),  32'(bus_err_v[d]), 32'h0);
      check_val($sformatf("d%0d reset err_addr", d), err_addr_v[d],     32'h0);
`endif
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      rst_n_v[d] = 1'b1;
      dce_v[d]   = 1'b0;
    end

    for (int d = 0; d < ND; d++) begin
      // Give every slave word a known value.
      for (int s = 0; s < NS; s++) begin
        for (int w = 0; w < 16; w++) begin
          txn(d, {4'(s), 22'b0, 4'(w), 2'b00}, 4'hF, $urandom);
        end
      end

      if (d == 0) begin
        txn(0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        txn(0, 32'h0000_0010, 4'h0, 32'h0);
        idle(0);
        txn(0, 32'h1000_0008, 4'h2, $urandom);
        txn(0, 32'h0000_0000, 4'h0, 32'h0);
        txn(0, 32'h1000_0000, 4'h0, 32'h0);
        idle(0);
        txn(0, 32'h3000_0000, 4'h0, 32'h0);
        txn(0, 32'h5000_0004, 4'h3, 32'h0BAD_F00D);
        idle(0);
      end else if (d == 1) begin
        txn(1, 32'h1000_0000, 4'hF, 32'h1234_5678);
        txn(1, 32'h1000_0000, 4'h0, 32'h0);
        txn(1, 32'h3000_0000, 4'h0, 32'h0);
        idle(1);
      end else begin
        reset_mid_wait(2);
        txn(2, 32'h1000_0000, 4'h0, 32'h0);
        idle(2);
      end

      for (int n = 0; n < 60; n++) begin
        logic [31:0] a;
        logic [3:0]  w;
        a = $urandom;
        case ($urandom_range(0, 4))
          0, 1:    a[31:28] = 4'h0;
          2, 3:    a[31:28] = 4'h1;
          default: a[31:28] = 4'($urandom_range(2, 15));
        endcase
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        txn(d, a, w, $urandom);
        idle_gaps = ($urandom_range(0, 2) == 0) ? 1 : 0;
        repeat (idle_gaps) idle(d);
      end
      repeat (lat_of(d) + 1) idle(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Parametrised data-side bus bridge between the MiniMIPS32 data port (dce/daddr/we/din/dm) and up to 16 synchronous memory-mapped slaves (data RAM banks, peripheral register files). It decodes a 4-bit region field of the address and routes each access to one slave. It supports slaves with read latency greater than one cycle by stalling the CPU. It replaces the direct single data_ram hookup at SoC level.

Parameters:
NUM_SLV, 2, number of slave channels, 1..16
RD_LAT, 1, slave read latency in cycles, 1..4; 1 = current block-RAM timing
SEL_LSB, 28, LSB of the 4-bit region field daddr[SEL_LSB+3:SEL_LSB]
AW_SLV, 11, slave word-address width; slave address = daddr[AW_SLV+1:2]

Ports:
cpu_clk_50M  in  1  sole clock, rising edge
cpu_rst_n  in  1  asynchronous active-low reset
dce  in  1  CPU data access enable
daddr  in  32  CPU byte address
we  in  4  CPU byte write enables; 0 = read
din  in  32  CPU write data
dm  out  32  read data to CPU
stall  out  1  CPU hold request, combinational
s_ce  out  NUM_SLV  per-slave enable, one-hot or zero
s_we  out  4*NUM_SLV  per-slave byte enables, slave i at [4i+3:4i]
s_addr  out  AW_SLV  shared word address
s_din  out  32  shared write data (= din)
s_dout  in  32*NUM_SLV  slave read data, slave i at [32i+31:32i]

Behaviour:
- Region index idx = daddr[SEL_LSB+3:SEL_LSB]; mapped iff idx < NUM_SLV.
- FSM states IDLE, WAIT. Reset: state=IDLE, cnt=0, idx_q=0, rpend_q=0; dm=0, stall=0, s_ce=0, s_we=0.
- Acceptance: only in IDLE with dce=1. In the acceptance cycle, s_ce[idx]=1, s_we[idx]=we, s_addr=daddr[AW_SLV+1:2], all combinational. Other channels are 0. While in WAIT, all s_ce and s_we are 0 regardless of dce.
- Write (we!=0): posted, single cycle, never stalls, rpend_q not set.
- Read (we==0), acceptance in cycle 0: idx_q<=idx, rpend counter starts.
  - RD_LAT=1: no stall; dm=s_dout[idx_q] in cycle 1. This is identical to the existing direct-RAM timing.
  - RD_LAT=L>1: stall=1 in cycle 0 (combinational on an IDLE read). Next state WAIT with cnt=1. In WAIT, stall=(cnt<L-1), cnt increments each cycle. When cnt==L-1, stall=0 and state returns to IDLE. dm is valid in cycle L.
  - The CPU holds dce/daddr/we stable while stall=1. The bridge does not re-issue s_ce during WAIT.
- dm = s_dout[idx_q] only in the response cycle (rvalid_q=1); otherwise dm=0.
- A new request accepted in the response cycle is legal (back-to-back). idx_q updates at the end of that cycle, so the current dm is unaffected.
- Unmapped read: no s_ce asserted; dm=0 in the response cycle; stall timing is the same as a mapped read.
- Unmapped write: dropped, no stall.
- Reset asserted mid-WAIT: immediate return to IDLE, stall=0, pending read discarded.

Optional Feature:
DMEM_BUS_ERR_EN:
- Defined: adds output bus_err (1) and output err_addr (32).
  - bus_err pulses for 1 cycle on an unmapped access: in the response cycle for reads, the cycle after acceptance for writes.
  - err_addr latches the offending daddr and holds it until the next error.
  - Both reset to 0.
- Undefined: ports absent; unmapped accesses are silently dropped or read as 0.

Test Plan:
- NUM_SLV=2, RD_LAT=1: write 0xDEADBEEF to 0x00000010 with we=0xF, then read 0x00000010 -> s_ce=01, s_addr=4; dm=0xDEADBEEF one cycle after the read; stall never high.
- Byte write we=0x2 to 0x10000008 -> s_ce=10, s_we[7:4]=0x2, s_we[3:0]=0, s_addr=2; no stall.
- RD_LAT=3: read 0x10000000 with slave 1 returning 0x12345678 -> stall high in cycles 0-1, low in cycle 2; dm=0x12345678 in cycle 3; s_ce high only in cycle 0.
- Back-to-back with RD_LAT=1: reads to 0x00000000 then 0x10000000 on consecutive cycles -> dm shows slave0 data then slave1 data in consecutive cycles.
- Unmapped read 0x30000000 (NUM_SLV=2), macro defined -> s_ce=0, dm=0, bus_err=1 for 1 cycle, err_addr=0x30000000. With the macro undefined: dm=0, no error ports.
- RD_LAT=4: assert cpu_rst_n=0 in cycle 1 of a read -> stall=0 and state IDLE immediately; after release, a new read completes normally.
